// File: rtl/la_trigger_capture_buffer_if.sv
// Capture-control and readout bundle for la_trigger_capture_buffer.
// master drives the stimulus/consumer side, slave is the capture buffer itself.
interface la_trigger_capture_buffer_if #(
   parameter int unsigned CH = 8,
   parameter int unsigned AW = 4
) ();
   logic [CH-1:0] in_data;
   logic          arm;
   logic [CH-1:0] pattern;
   logic [CH-1:0] mask;
   logic          edge_mode;
   logic [AW-1:0] pre_count;
   logic          rd_en;
   logic [CH-1:0] rd_data;
   logic          rd_valid;
   logic [2:0]    state;
   logic          triggered;
   logic [AW-1:0] trig_pos;
   logic          done;

   modport master (
      output in_data, arm, pattern, mask, edge_mode, pre_count, rd_en,
      input  rd_data, rd_valid, state, triggered, trig_pos, done
   );

   modport slave (
      input  in_data, arm, pattern, mask, edge_mode, pre_count, rd_en,
      output rd_data, rd_valid, state, triggered, trig_pos, done
   );
endinterface

// File: rtl/la_trigger_capture_buffer.sv
// Logic-analyzer trigger with a DEPTH-sample circular capture window and oldest-first readout.
// Optional macro LA_TRIG_EDGE_EN adds rising-edge trigger qualification via edge_mode.
module la_trigger_capture_buffer #(
   parameter  int unsigned CH    = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input logic                   clk,
   input logic                   rst_n,
   la_trigger_capture_buffer_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFill  = 3'd1,
      StArmed = 3'd2,
      StPost  = 3'd3,
      StRead  = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] rd_cnt_q, rd_cnt_d;
   logic [AW-1:0] pre_q, pre_d;
   logic          triggered_q, triggered_d;
   logic          done_q, done_d;
   logic [CH-1:0] sample_q;
   logic [CH-1:0] mem [DEPTH];

   logic match, fire, wr_en;

   assign match = ((sample_q ^ bus.pattern) & bus.mask) == '0;
   assign wr_en = (state_q == StFill) || (state_q == StArmed) || (state_q == StPost);

`ifdef LA_TRIG_EDGE_EN
   logic match_prev_q;

   // Held at 1 outside ARMED so a pattern already present at arming cannot fire.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         match_prev_q <= 1'b1;
      end else if (state_q != StArmed) begin
         match_prev_q <= 1'b1;
      end else begin
         match_prev_q <= match;
      end
   end

   assign fire = bus.edge_mode ? (match && !match_prev_q) : match;
`else
   logic unused_edge_mode;
   assign unused_edge_mode = bus.edge_mode;
   assign fire = match;
`endif

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      rd_cnt_d    = rd_cnt_q;
      pre_d       = pre_q;
      triggered_d = triggered_q;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.arm) begin
               // pre_count is AW bits wide, so it can never exceed DEPTH-1.
               pre_d       = bus.pre_count;
               cnt_d       = bus.pre_count;
               wr_ptr_d    = '0;
               triggered_d = 1'b0;
               state_d     = (bus.pre_count != '0) ? StFill : StArmed;
            end
         end
         StFill: begin
            cnt_d = cnt_q - AW'(1);
            if (cnt_q == AW'(1)) state_d = StArmed;
         end
         StArmed: begin
            if (fire) begin
               triggered_d = 1'b1;
               cnt_d       = AW'(DEPTH - 1) - pre_q;
               if (pre_q == AW'(DEPTH - 1)) begin
                  state_d  = StRead;
                  rd_ptr_d = wr_ptr_q + AW'(1);
                  rd_cnt_d = '0;
               end else begin
                  state_d = StPost;
               end
            end
         end
         StPost: begin
            cnt_d = cnt_q - AW'(1);
            if (cnt_q == AW'(1)) begin
               state_d  = StRead;
               rd_ptr_d = wr_ptr_q + AW'(1);
               rd_cnt_d = '0;
            end
         end
         StRead: begin
            if (bus.rd_en) begin
               rd_ptr_d = rd_ptr_q + AW'(1);
               rd_cnt_d = rd_cnt_q + AW'(1);
               if (rd_cnt_q == AW'(DEPTH - 1)) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         rd_cnt_q    <= '0;
         pre_q       <= '0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
         sample_q    <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         pre_q       <= pre_d;
         triggered_q <= triggered_d;
         done_q      <= done_d;
         sample_q    <= bus.in_data;
      end
   end

   // Capture storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= sample_q;
   end

   assign bus.rd_data   = mem[rd_ptr_q];
   assign bus.rd_valid  = (state_q == StRead);
   assign bus.state     = state_q;
   assign bus.triggered = triggered_q;
   assign bus.trig_pos  = pre_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_la_trigger_capture_buffer.sv
// Self-checking bench for la_trigger_capture_buffer (CH=8, DEPTH=16) with a readout scoreboard.
module tb_la_trigger_capture_buffer;
   localparam int unsigned CH    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   la_trigger_capture_buffer_if #(.CH(CH), .AW(AW)) bus ();

   la_trigger_capture_buffer #(.CH(CH), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail = 0;
   logic [CH-1:0] stim[$];
   logic [CH-1:0] exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ramp 0,1,2,... with trig_v placed at index t.
   task automatic build_stim(input int t, input logic [CH-1:0] trig_v);
      stim.delete();
      for (int i = 0; i <= t; i++) stim.push_back((i == t) ? trig_v : CH'(i));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_checks++;
      if (bus.state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.state); end
      n_checks++;
      if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
      n_checks++;
      if (bus.triggered !== 1'b0) begin n_fail++; $display("FAIL reset_triggered got %b want 0", bus.triggered); end
      n_checks++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
      n_checks++;
      if (bus.trig_pos !== 4'd0) begin n_fail++; $display("FAIL reset_trig_pos got %0d want 0", bus.trig_pos); end
      rst_n = 1'b1;
      tick();
   endtask

   // Arms, streams stim (trigger at index t), then drains and scores the window.
   task automatic capture(input string name, input int pre_in, input int exp_pre,
                          input logic [CH-1:0] pat, input logic [CH-1:0] msk, input logic em,
                          input int t, input int duty, input bit arm_in_read);
      int pops, cyc, waitc;
      logic [CH-1:0] exp_v;
      bit armed_now;
      while (stim.size() < t + DEPTH - exp_pre + 2) stim.push_back(CH'(8'h40 + stim.size()));
      exp_q.delete();
      for (int k = 0; k < DEPTH; k++) exp_q.push_back(stim[t - exp_pre + k]);

      bus.pattern   = pat;
      bus.mask      = msk;
      bus.edge_mode = em;
      bus.pre_count = AW'(pre_in);
      bus.rd_en     = 1'b0;
      bus.arm       = 1'b1;
      bus.in_data   = stim[0];
      tick();
      bus.arm = 1'b0;
      n_checks++;
      if (bus.state !== ((exp_pre > 0) ? 3'd1 : 3'd2)) begin
         n_fail++;
         $display("FAIL %s arm_state got %0d want %0d", name, bus.state, (exp_pre > 0) ? 1 : 2);
      end
      for (int i = 1; i < stim.size(); i++) begin
         bus.in_data = stim[i];
         tick();
      end
      waitc = 0;
      while (bus.state !== 3'd4 && waitc < 40) begin
         tick();
         waitc++;
      end
      n_checks++;
      if (bus.state !== 3'd4) begin
         n_fail++;
         $display("FAIL %s reach_read got state %0d want 4", name, bus.state);
         return;
      end
      n_checks++;
      if (bus.trig_pos !== AW'(exp_pre)) begin
         n_fail++; $display("FAIL %s trig_pos got %0d want %0d", name, bus.trig_pos, exp_pre);
      end
      n_checks++;
      if (bus.triggered !== 1'b1) begin
         n_fail++; $display("FAIL %s triggered got %b want 1", name, bus.triggered);
      end

      pops = 0;
      cyc  = 0;
      while (pops < DEPTH && cyc < 2000) begin
         bus.rd_en = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
         armed_now = arm_in_read && (cyc == 3);
         bus.arm = armed_now;
         if (bus.rd_en && bus.rd_valid) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (bus.rd_data !== exp_v) begin
               n_fail++;
               $display("FAIL %s read[%0d] got %h want %h", name, pops, bus.rd_data, exp_v);
            end
            pops++;
         end
         tick();
         bus.arm = 1'b0;
         cyc++;
         if (armed_now && pops < DEPTH) begin
            n_checks++;
            if (bus.state !== 3'd4) begin
               n_fail++; $display("FAIL %s arm_in_read state got %0d want 4", name, bus.state);
            end
         end
      end
      n_checks++;
      if (pops != DEPTH) begin
         n_fail++; $display("FAIL %s pop_count got %0d want %0d", name, pops, DEPTH);
      end
      n_checks++;
      if (bus.done !== 1'b1 || bus.state !== 3'd0 || bus.rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s end done/state/valid got %b/%0d/%b want 1/0/0",
                  name, bus.done, bus.state, bus.rd_valid);
      end
      bus.rd_en = 1'b1;
      tick();
      n_checks++;
      if (bus.done !== 1'b0 || bus.state !== 3'd0 || bus.rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after_done done/state/valid got %b/%0d/%b want 0/0/0",
                  name, bus.done, bus.state, bus.rd_valid);
      end
      n_checks++;
      if (bus.triggered !== 1'b1) begin
         n_fail++; $display("FAIL %s triggered_hold got %b want 1", name, bus.triggered);
      end
      bus.rd_en = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_capture();
      build_stim(7, 8'hA5);
      bus.pattern   = 8'hA5;
      bus.mask      = 8'hFF;
      bus.edge_mode = 1'b0;
      bus.pre_count = 4'd4;
      bus.arm       = 1'b1;
      bus.in_data   = stim[0];
      tick();
      bus.arm = 1'b0;
      for (int i = 1; i < 11; i++) begin
         bus.in_data = (i < stim.size()) ? stim[i] : CH'(8'h50 + i);
         tick();
      end
      n_checks++;
      if (bus.state !== 3'd3) begin n_fail++; $display("FAIL midrst in_post got %0d want 3", bus.state); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_checks++;
      if (bus.state !== 3'd0) begin n_fail++; $display("FAIL midrst state got %0d want 0", bus.state); end
      n_checks++;
      if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst rd_valid got %b want 0", bus.rd_valid); end
      n_checks++;
      if (bus.triggered !== 1'b0) begin n_fail++; $display("FAIL midrst triggered got %b want 0", bus.triggered); end
      n_checks++;
      if (bus.trig_pos !== 4'd0) begin n_fail++; $display("FAIL midrst trig_pos got %0d want 0", bus.trig_pos); end
      tick();
   endtask

   task automatic test_pre_placement();
      build_stim(9, 8'hA5);
      capture("pre4", 4, 4, 8'hA5, 8'hFF, 1'b0, 9, 100, 1'b0);
   endtask

   task automatic test_pre_zero();
      build_stim(0, 8'h3C);
      capture("pre0_mask0", 0, 0, 8'h00, 8'h00, 1'b0, 0, 100, 1'b0);
   endtask

   task automatic test_pre_max();
      build_stim(18, 8'hA5);
      capture("pre15", 15, 15, 8'hA5, 8'hFF, 1'b0, 18, 100, 1'b0);
   endtask

   task automatic test_ring_wrap();
      build_stim(42, 8'hA5);
      capture("ring_wrap", 2, 2, 8'hA5, 8'hFF, 1'b0, 42, 100, 1'b0);
   endtask

   task automatic test_backpressure();
      build_stim(10, 8'hA5);
      capture("backpressure", 4, 4, 8'hA5, 8'hFF, 1'b0, 10, 30, 1'b1);
   endtask

   task automatic test_edge_mode();
      int t;
      stim.delete();
      for (int i = 0; i < 5; i++) stim.push_back(8'hA5);
      stim.push_back(8'h11);
      stim.push_back(8'h12);
      stim.push_back(8'hA5);
`ifdef LA_TRIG_EDGE_EN
      t = 7;
`else
      t = 0;
`endif
      capture("edge_mode", 0, 0, 8'hA5, 8'hFF, 1'b1, t, 100, 1'b0);
   endtask

   initial begin
      bus.in_data   = '0;
      bus.arm       = 1'b0;
      bus.pattern   = '0;
      bus.mask      = '0;
      bus.edge_mode = 1'b0;
      bus.pre_count = '0;
      bus.rd_en     = 1'b0;
      test_reset();
      test_reset_mid_capture();
      test_pre_placement();
      test_pre_zero();
      test_pre_max();
      test_ring_wrap();
      test_backpressure();
      test_edge_mode();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout after %0d checks", n_checks);
      $fatal(1, "watchdog");
   end
endmodule
